// File: rtl/adsr_envelope_gen.sv
// -----------------------------------------------------------------------------
// adsr_envelope_gen
//
// Purpose: ADSR envelope generator placed between the note/key logic and the
// voice amplitude multiplier. It provides attack, decay, sustain and release
// stages. A gate rising edge retriggers the attack without resetting the level.
// Widths are configurable. Level changes happen only on sample_tick. Gate
// events are evaluated on every clk.
//
// Ports:
//   clk           - system clock
//   rst           - asynchronous, active-low reset
//   sample_tick   - one-clk strobe that advances the envelope
//   attack_time   - extra ticks per attack step   (one step every T+1 ticks)
//   decay_time    - extra ticks per decay step
//   sustain_level - sustain target level, tracked live while in SUSTAIN
//   release_time  - extra ticks per release step
//   amplitude     - output scale factor
//   gate          - note held
//   envelope      - registered (L * amplitude) >> (LVL_W + AMP_W - OUT_W)
//   stage         - registered stage: IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active        - high whenever stage != IDLE
// -----------------------------------------------------------------------------
module adsr_envelope_gen #(
  parameter int TIME_W = 16,
  parameter int LVL_W  = 8,
  parameter int AMP_W  = 7,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [TIME_W-1:0] attack_time,
  input  logic [TIME_W-1:0] decay_time,
  input  logic [LVL_W-1:0]  sustain_level,
  input  logic [TIME_W-1:0] release_time,
  input  logic [AMP_W-1:0]  amplitude,
  input  logic              gate,
  output logic [OUT_W-1:0]  envelope,
  output logic [2:0]        stage,
  output logic              active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_e;

  localparam int             PROD_W = LVL_W + AMP_W;
  localparam int             SHIFT  = PROD_W - OUT_W;
  localparam logic [LVL_W-1:0] LMAX = '1;

  stage_e              stage_q, stage_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [TIME_W-1:0]   div_cnt_q, div_cnt_d;
  logic                gate_prev_q;
  logic [OUT_W-1:0]    env_q, env_d;

  logic                gate_rise;
  logic [TIME_W-1:0]   cur_time;
  logic                step_due;
  logic [TIME_W-1:0]   div_adv;
  logic [PROD_W-1:0]   prod;

  assign gate_rise = gate & ~gate_prev_q;

  // Time input for the stage being stepped. It is sampled live, so a change
  // takes effect at the next compare.
  always_comb begin
    cur_time = attack_time;
    case (stage_q)
      ST_DECAY:   cur_time = decay_time;
      ST_RELEASE: cur_time = release_time;
      default:    cur_time = attack_time;
    endcase
  end

  // On a tick, either a level step is due (and the divider restarts) or the
  // divider counts up.
  assign step_due = (div_cnt_q >= cur_time);
  assign div_adv  = step_due ? '0 : div_cnt_q + TIME_W'(1);

  always_comb begin
    stage_d   = stage_q;
    lvl_d     = lvl_q;
    div_cnt_d = div_cnt_q;

    if (gate_rise) begin
      // Retrigger from any stage. Keeping the level avoids an audible click.
      stage_d   = ST_ATTACK;
      div_cnt_d = '0;
    end else if (!gate && (stage_q == ST_ATTACK || stage_q == ST_DECAY ||
                           stage_q == ST_SUSTAIN)) begin
      stage_d   = ST_RELEASE;
      div_cnt_d = '0;
    end else begin
      case (stage_q)
        ST_IDLE: begin
          lvl_d = '0;
        end
        ST_ATTACK: begin
          if (sample_tick) begin
            if (lvl_q == LMAX) begin
              // The peak costs one extra tick. No step is applied on it.
              stage_d   = ST_DECAY;
              div_cnt_d = '0;
            end else begin
              div_cnt_d = div_adv;
              if (step_due) lvl_d = lvl_q + LVL_W'(1);
            end
          end
        end
        ST_DECAY: begin
          if (sample_tick) begin
            if (lvl_q <= sustain_level) begin
              stage_d = ST_SUSTAIN;
              lvl_d   = sustain_level;
            end else begin
              div_cnt_d = div_adv;
              if (step_due) lvl_d = lvl_q - LVL_W'(1);
            end
          end
        end
        ST_SUSTAIN: begin
          lvl_d = sustain_level;
        end
        ST_RELEASE: begin
          if (sample_tick) begin
            if (lvl_q == '0) begin
              stage_d = ST_IDLE;
            end else begin
              div_cnt_d = div_adv;
              if (step_due) lvl_d = lvl_q - LVL_W'(1);
            end
          end
        end
        default: begin
          stage_d = ST_IDLE;
          lvl_d   = '0;
        end
      endcase
    end
  end

  // Full-width unsigned product. Keep the top OUT_W bits.
  assign prod  = PROD_W'(lvl_q) * PROD_W'(amplitude);
  assign env_d = OUT_W'(prod >> SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q     <= ST_IDLE;
      lvl_q       <= '0;
      div_cnt_q   <= '0;
      gate_prev_q <= 1'b0;
      env_q       <= '0;
    end else begin
      stage_q     <= stage_d;
      lvl_q       <= lvl_d;
      div_cnt_q   <= div_cnt_d;
      gate_prev_q <= gate;
      env_q       <= env_d;
    end
  end

  assign envelope = env_q;
  assign stage    = stage_q;
  assign active   = (stage_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// -----------------------------------------------------------------------------
// tb_adsr_envelope_gen
//
// Purpose: self-checking bench for adsr_envelope_gen with default parameters.
// A short table of single-clk vectors covers gate and tick interactions. Then
// hand-written sequences cover the full ADSR cycle, early release, retrigger,
// divider and freeze, the boundaries, and reset mid-attack.
// -----------------------------------------------------------------------------
module tb_adsr_envelope_gen;

  logic        clk;
  logic        rst;
  logic        sample_tick;
  logic [15:0] attack_time;
  logic [15:0] decay_time;
  logic [7:0]  sustain_level;
  logic [15:0] release_time;
  logic [6:0]  amplitude;
  logic        gate;
  logic [7:0]  envelope;
  logic [2:0]  stage;
  logic        active;

  int checks = 0;
  int errors = 0;

  localparam int IDLE = 0, ATT = 1, DEC = 2, SUS = 3, REL = 4;

  adsr_envelope_gen dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .attack_time  (attack_time),
    .decay_time   (decay_time),
    .sustain_level(sustain_level),
    .release_time (release_time),
    .amplitude    (amplitude),
    .gate         (gate),
    .envelope     (envelope),
    .stage        (stage),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic       gate;
    logic       tick;
    logic [2:0] exp_stage;
    logic [7:0] exp_lvl;
    logic [7:0] exp_env;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end else begin
      $display("check %s: got %0d ok", name, actual);
    end
  endtask

  // One tick every gap clks. Returns on the negedge after the tick's posedge,
  // plus gap-2 further negedges.
  task automatic tick_n(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) sample_tick = 1'b1;
      @(negedge clk) sample_tick = 1'b0;
      repeat (gap - 2) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; gate = 1'b0; sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_params(input int a, input int d, input int s, input int r, input int amp);
    attack_time   = 16'(a);
    decay_time    = 16'(d);
    sustain_level = 8'(s);
    release_time  = 16'(r);
    amplitude     = 7'(amp);
  endtask

  initial begin
    bit saw_decay;
    rst = 1'b0; sample_tick = 1'b0; gate = 1'b0;
    set_params(0, 0, 2, 0, 127);

    // Table: A=D=R=0, S=2, amp=127. Envelope lags L by one clk.
    vecs[0]  = '{1'b1, 1'b0, 3'(ATT), 8'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 3'(ATT), 8'd1, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 3'(ATT), 8'd2, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 3'(ATT), 8'd2, 8'd1};
    vecs[4]  = '{1'b1, 1'b1, 3'(ATT), 8'd3, 8'd1};
    vecs[5]  = '{1'b0, 1'b1, 3'(REL), 8'd3, 8'd2};
    vecs[6]  = '{1'b0, 1'b1, 3'(REL), 8'd2, 8'd2};
    vecs[7]  = '{1'b1, 1'b1, 3'(ATT), 8'd2, 8'd1};
    vecs[8]  = '{1'b1, 1'b1, 3'(ATT), 8'd3, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 3'(REL), 8'd3, 8'd2};
    vecs[10] = '{1'b0, 1'b1, 3'(REL), 8'd2, 8'd2};
    vecs[11] = '{1'b0, 1'b1, 3'(REL), 8'd1, 8'd1};
    vecs[12] = '{1'b0, 1'b1, 3'(REL), 8'd0, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 3'(REL), 8'd0, 8'd0};
    vecs[14] = '{1'b0, 1'b1, 3'(IDLE), 8'd0, 8'd0};
    vecs[15] = '{1'b0, 1'b1, 3'(IDLE), 8'd0, 8'd0};

    // Reset state
    #1;
    check("rst_envelope", int'(envelope), 0);
    check("rst_stage", int'(stage), IDLE);
    check("rst_active", int'(active), 0);
    check("rst_level", int'(dut.lvl_q), 0);
    check("rst_div", int'(dut.div_cnt_q), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single-clk vectors
    for (int i = 0; i < 16; i++) begin
      gate = vecs[i].gate;
      sample_tick = vecs[i].tick;
      @(negedge clk);
      check($sformatf("vec%0d_stage", i), int'(stage), int'(vecs[i].exp_stage));
      check($sformatf("vec%0d_level", i), int'(dut.lvl_q), int'(vecs[i].exp_lvl));
      check($sformatf("vec%0d_env", i), int'(envelope), int'(vecs[i].exp_env));
      check($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].exp_stage != 3'(IDLE)));
    end
    sample_tick = 1'b0;

    // Basic ADSR: tick every 10 clk
    do_reset();
    set_params(1, 0, 128, 0, 127);
    gate = 1'b1;
    @(negedge clk);
    check("basic_attack_entry", int'(stage), ATT);
    tick_n(509, 10);
    check("basic_l_509", int'(dut.lvl_q), 254);
    tick_n(1, 10);
    check("basic_peak_level", int'(dut.lvl_q), 255);
    check("basic_peak_env", int'(envelope), 253);
    check("basic_peak_stage", int'(stage), ATT);
    tick_n(1, 10);
    check("basic_decay_entry", int'(stage), DEC);
    check("basic_decay_l", int'(dut.lvl_q), 255);
    tick_n(127, 10);
    check("basic_decay_end_stage", int'(stage), DEC);
    check("basic_decay_end_l", int'(dut.lvl_q), 128);
    tick_n(1, 10);
    check("basic_sustain_stage", int'(stage), SUS);
    check("basic_sustain_env", int'(envelope), 127);
    gate = 1'b0;
    @(negedge clk);
    check("basic_release_entry", int'(stage), REL);
    check("basic_release_l", int'(dut.lvl_q), 128);
    tick_n(128, 10);
    check("basic_release_l0", int'(dut.lvl_q), 0);
    check("basic_release_still", int'(stage), REL);
    tick_n(1, 10);
    check("basic_idle_stage", int'(stage), IDLE);
    check("basic_idle_env", int'(envelope), 0);
    check("basic_idle_active", int'(active), 0);

    // Early release
    do_reset();
    set_params(0, 0, 128, 0, 127);
    gate = 1'b1;
    tick_n(40, 2);
    check("early_l40", int'(dut.lvl_q), 40);
    gate = 1'b0;
    @(negedge clk);
    check("early_release_stage", int'(stage), REL);
    check("early_release_l", int'(dut.lvl_q), 40);
    saw_decay = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick_n(1, 2);
      if (stage == 3'(DEC)) saw_decay = 1'b1;
    end
    check("early_no_decay", int'(saw_decay), 0);
    check("early_l0", int'(dut.lvl_q), 0);
    tick_n(1, 2);
    check("early_idle", int'(stage), IDLE);

    // Retrigger during release
    do_reset();
    set_params(0, 0, 128, 0, 127);
    gate = 1'b1;
    tick_n(100, 2);
    gate = 1'b0;
    @(negedge clk);
    tick_n(36, 2);
    check("retrig_rel_l64", int'(dut.lvl_q), 64);
    check("retrig_rel_stage", int'(stage), REL);
    gate = 1'b1;
    @(negedge clk);
    check("retrig_attack_stage", int'(stage), ATT);
    check("retrig_attack_l", int'(dut.lvl_q), 64);
    tick_n(190, 2);
    check("retrig_l254", int'(dut.lvl_q), 254);
    tick_n(1, 2);
    check("retrig_l255", int'(dut.lvl_q), 255);
    check("retrig_still_attack", int'(stage), ATT);

    // Divider and freeze, A=3
    do_reset();
    set_params(3, 0, 128, 0, 127);
    gate = 1'b1;
    @(negedge clk);
    tick_n(3, 2);
    check("div_l_after3", int'(dut.lvl_q), 0);
    tick_n(1, 2);
    check("div_l_after4", int'(dut.lvl_q), 1);
    tick_n(4, 2);
    check("div_l_after8", int'(dut.lvl_q), 2);
    tick_n(2, 2);
    check("div_cnt_2", int'(dut.div_cnt_q), 2);
    repeat (1000) @(negedge clk);
    check("freeze_l", int'(dut.lvl_q), 2);
    check("freeze_div", int'(dut.div_cnt_q), 2);
    check("freeze_stage", int'(stage), ATT);
    tick_n(1, 2);
    check("div_l_after11", int'(dut.lvl_q), 2);
    tick_n(1, 2);
    check("div_l_after12", int'(dut.lvl_q), 3);

    // S=255 and live sustain tracking
    do_reset();
    set_params(0, 0, 255, 0, 127);
    gate = 1'b1;
    tick_n(256, 2);
    check("s255_decay_entry", int'(stage), DEC);
    tick_n(1, 2);
    check("s255_sustain_stage", int'(stage), SUS);
    check("s255_sustain_l", int'(dut.lvl_q), 255);
    sustain_level = 8'd128;
    @(negedge clk);
    check("s_track_128", int'(dut.lvl_q), 128);
    sustain_level = 8'd200;
    @(negedge clk);
    check("s_track_200", int'(dut.lvl_q), 200);

    // amplitude = 0
    do_reset();
    set_params(0, 0, 250, 0, 0);
    gate = 1'b1;
    tick_n(255, 2);
    @(negedge clk);
    check("amp0_attack_l", int'(dut.lvl_q), 255);
    check("amp0_attack_env", int'(envelope), 0);
    tick_n(7, 2);
    @(negedge clk);
    check("amp0_sustain_stage", int'(stage), SUS);
    check("amp0_sustain_env", int'(envelope), 0);
    gate = 1'b0;
    tick_n(10, 2);
    @(negedge clk);
    check("amp0_release_stage", int'(stage), REL);
    check("amp0_release_l", int'(dut.lvl_q), 240);
    check("amp0_release_env", int'(envelope), 0);

    // Reset mid-attack
    do_reset();
    set_params(0, 0, 128, 0, 127);
    gate = 1'b1;
    tick_n(100, 2);
    check("rstmid_l100", int'(dut.lvl_q), 100);
    rst = 1'b0;
    #1;
    check("rstmid_env", int'(envelope), 0);
    check("rstmid_stage", int'(stage), IDLE);
    check("rstmid_l", int'(dut.lvl_q), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_restart_stage", int'(stage), ATT);
    check("rstmid_restart_l", int'(dut.lvl_q), 0);
    tick_n(1, 2);
    check("rstmid_first_step", int'(dut.lvl_q), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adsr_envelope_gen.md
# adsr_envelope_gen

Parametrised ADSR envelope generator. It is the successor to the two-stage attack/decay generator: it adds sustain and release stages, gate-driven retrigger without a level reset, and configurable widths. It sits between the note/key logic and the voice amplitude multiplier. All level changes happen on the shared `sample_tick` strobe from the clock divider.

## Interface
Parameters:
- `TIME_W`, 16: width of the attack, decay and release time inputs.
- `LVL_W`, 8: width of the internal level register `L`. `LMAX = 2^LVL_W - 1`.
- `AMP_W`, 7: width of the amplitude input.
- `OUT_W`, 8: width of the envelope output. Constraint: `OUT_W <= LVL_W + AMP_W`.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `sample_tick`, in, 1: one-`clk`-wide strobe that advances the envelope.
- `attack_time`, in, TIME_W: extra ticks per attack step.
- `decay_time`, in, TIME_W: extra ticks per decay step.
- `sustain_level`, in, LVL_W: sustain target level.
- `release_time`, in, TIME_W: extra ticks per release step.
- `amplitude`, in, AMP_W: output scale.
- `gate`, in, 1: note held.
- `envelope`, out, OUT_W: scaled envelope, registered.
- `stage`, out, 3: current stage. IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Registered.
- `active`, out, 1: high when `stage != IDLE`.

## Operation
- Internal registers: `L` (LVL_W bits), step divider `div_cnt` (TIME_W bits), `gate_d` (previous `gate`).
- Step rule for the ATTACK, DECAY and RELEASE stages, with `T` = that stage's time input:
  - On a `sample_tick`, if `div_cnt >= T`: set `div_cnt <= 0` and apply one level step.
  - On a `sample_tick` otherwise: `div_cnt <= div_cnt + 1`.
  - So one step occurs every `T+1` ticks. `T=0` gives one step per tick.
  - `T` is sampled live; a change mid-stage takes effect at the next compare.
- IDLE: `L` holds 0. A gate rising edge (`gate & ~gate_d`) moves to ATTACK.
- ATTACK:
  - Step is `L <= L+1`.
  - If `L == LMAX` on a tick: go to DECAY, with no step and `div_cnt <= 0`.
- DECAY:
  - If `L <= sustain_level` on a tick: go to SUSTAIN and set `L <= sustain_level`.
  - Otherwise the step is `L <= L-1`.
  - `sustain_level == LMAX` therefore goes to SUSTAIN on the first decay tick.
- SUSTAIN: `L <= sustain_level` every clk, tracking changes live. No stepping.
- RELEASE:
  - Step is `L <= L-1`.
  - If `L == 0` on a tick: go to IDLE.
- Gate events are evaluated every clk, independent of `sample_tick`:
  - Gate rising edge in any state: go to ATTACK, `div_cnt <= 0`, `L` retained (no click).
  - `gate == 0` while in ATTACK, DECAY or SUSTAIN: go to RELEASE, `div_cnt <= 0`, `L` retained.
- Priority within one clk: reset > gate rising edge > gate low > tick processing. A gate event in the same clk as a tick suppresses that tick's step.
- Output scaling: `envelope <= (L * amplitude) >> (LVL_W + AMP_W - OUT_W)`, using the full-width unsigned product, recomputed every clk.
- `L` never wraps. It saturates at LMAX in ATTACK and at 0 in RELEASE.

## Timing
- Reset (async assert, `rst = 0`): `L=0`, `div_cnt=0`, `gate_d=0`, `stage=IDLE`, `envelope=0`, `active=0`.
- Reset deassert with `gate` already high: treated as a rising edge, so `stage=ATTACK` one clk after the first clk edge.
- Gate-to-stage latency: 1 clk. Tick-to-`L` latency: 1 clk. `L`-to-`envelope` latency: 1 further clk.
- Reset mid-stage: immediate return to reset values. No residual level.
- No `sample_tick`: `L` and `div_cnt` freeze. Gate-driven stage changes still occur.
- Full cycle from 0 with constant inputs:
  - ATTACK to peak: `LMAX*(A+1)` ticks, plus 1 tick to enter DECAY.
  - DECAY: `(LMAX - S)*(D+1)` ticks, plus 1 tick to enter SUSTAIN.
  - RELEASE from sustain: `S*(R+1)` ticks, plus 1 tick to enter IDLE.

## Test plan
- Basic ADSR:
  - Stimulus: defaults, tick every 10 clk, A=1, D=0, S=128, R=0, amplitude=127, gate high.
  - Peak: L=255 after 510 ticks, `envelope`=253.
  - Decay: SUSTAIN after 127 more steps plus 1 tick, `envelope`=127.
  - Release: gate low, IDLE after 128 steps plus 1 tick, `envelope`=0, `active`=0.
- Early release:
  - Stimulus: A=0, gate low when L=40.
  - Response: `stage`=RELEASE next clk. L counts 40→0 without visiting DECAY.
- Retrigger:
  - Stimulus: gate rising edge during RELEASE at L=64, A=0.
  - Response: ATTACK resumes from 64 and reaches 255 after 191 ticks.
- Divider and freeze:
  - Stimulus: A=3.
  - Response: L increments exactly every 4th tick. With `sample_tick` held low for 1000 clk, L and `div_cnt` are unchanged.
- Boundaries:
  - S=255: SUSTAIN on the first decay tick with L=255.
  - amplitude=0: `envelope`=0 in every stage while stages still progress.
  - S changed 128→200 in SUSTAIN: L=200 next clk.
- Reset mid-attack:
  - Stimulus: `rst` pulsed low at L=100.
  - Response: `envelope`, `stage` and L are 0/IDLE immediately.
  - After release with gate high, ATTACK restarts from L=0.
